// File: rtl/ysyx_23060042_lsu_pkg.sv
// ============================================================================
// Module : ysyx_23060042_lsu_pkg
// Brief  : Shared types and alignment check for the load/store unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060042_lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Size code 3 has no encoding and is reported the same way as misalignment.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == 2'd3) ||
             ((size == SZ_H) && off[0]) ||
             ((size == SZ_W) && (off != 2'd0));
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060042_lsu_align.sv
// ============================================================================
// Module : ysyx_23060042_lsu_align
// Brief  : Byte-lane steering for stores and extraction/extension for loads.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060042_lsu_align
   import ysyx_23060042_lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_wmask,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   logic [31:0] w_shifted;

   always_comb begin
      w_shifted  = i_rdata >> {i_offset, 3'b000};
      o_wmask    = 4'hF;
      o_wdata    = i_wdata;
      o_rdata    = i_rdata;
      o_misalign = lsu_misaligned(i_size, i_offset);
      case (i_size)
         SZ_B: begin
            o_wmask = 4'b0001 << i_offset;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = i_unsigned ? {24'h0, w_shifted[7:0]}
                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_H: begin
            o_wmask = 4'b0011 << i_offset;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = i_unsigned ? {16'h0, w_shifted[15:0]}
                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060042_lsu.sv
// ============================================================================
// Module : ysyx_23060042_lsu
// Brief  : Multi-cycle load/store unit; optional WAIT timeout via LSU_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060042_lsu
   import ysyx_23060042_lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   output logic [3:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_rdata
);

   lsu_state_t        r_state, w_next;
   logic              r_wen, r_unsigned, r_err;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_rdata;
   logic [3:0]        w_wmask;
   logic [31:0]       w_wdata, w_ld_data;
   logic              w_lat_misalign, w_req_misalign;

   assign w_req_misalign = lsu_misaligned(req_size, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wcnt;
   logic             w_timeout;

   assign w_timeout = (r_wcnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Cleared while in REQ so the count starts at zero on WAIT entry.
   always_ff @(posedge clk) begin
      if (rst)                 r_wcnt <= '0;
      else if (r_state == REQ) r_wcnt <= '0;
      else if (r_state == WAIT) r_wcnt <= r_wcnt + 1'b1;
   end
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   ysyx_23060042_lsu_align u_align (
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_offset   (r_addr[1:0]),
      .i_rdata    (mem_resp_rdata),
      .i_wdata    (r_wdata),
      .o_wmask    (w_wmask),
      .o_wdata    (w_wdata),
      .o_rdata    (w_ld_data),
      .o_misalign (w_lat_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      mem_req_valid = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = !rst;
            if (req_valid) w_next = w_req_misalign ? RESP : REQ;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) w_next = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid) w_next = RESP;
`ifdef LSU_TIMEOUT_EN
            else if (w_timeout) w_next = RESP;
`endif
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen      <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_wen      <= req_wen;
               r_size     <= req_size;
               r_unsigned <= req_unsigned;
               r_addr     <= req_addr;
               r_wdata    <= req_wdata;
               r_err      <= w_req_misalign;
               r_rdata    <= 32'h0;
            end
            WAIT: begin
               if (mem_resp_valid) r_rdata <= r_wen ? 32'h0 : w_ld_data;
`ifdef LSU_TIMEOUT_EN
               else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= 32'h0;
               end
`endif
            end
            RESP: if (resp_ready) begin
               r_err   <= 1'b0;
               r_rdata <= 32'h0;
            end
            default: ;
         endcase
      end
   end

   // A rejected access never exposes a byte mask.
   assign mem_req_wen   = r_wen;
   assign mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
   assign mem_req_wdata = w_wdata;
   assign mem_req_wmask = (r_wen && !w_lat_misalign) ? w_wmask : 4'h0;
   assign resp_rdata    = r_rdata;
   assign resp_err      = r_err;

endmodule

`default_nettype wire
